excp_irq_ctrl: RTL and testbench
================================

# excp_irq_ctrl

Parametrised machine-mode interrupt controller inside the exception unit. It replaces the fixed three-line request/cause logic with NUM_SRC external sources, per-source edge/level gateways, priority/threshold arbitration, and a claim/complete handshake. It presents the merged request, WFI wake and mcause value to the exception top and the PC unit.

## Interface
- XLEN, 32, width of irq_cause.
- NUM_SRC, 8, number of external interrupt sources (2..32).
- PRIO_W, 3, per-source priority width. Priority 0 means never eligible.
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- dbg_mode  in  1  debug mode. Masks all requests and wake.
- src_irq  in  NUM_SRC  raw external lines, synchronous to clk.
- src_edge  in  NUM_SRC  per-source mode: 1 = rising edge, 0 = level.
- src_en  in  NUM_SRC  per-source enable.
- src_prio  in  NUM_SRC*PRIO_W  packed priorities. Source i occupies [i*PRIO_W +: PRIO_W].
- prio_thresh  in  PRIO_W  a source is eligible only if its priority > prio_thresh.
- sft_irq, tmr_irq  in  1 each  software and timer lines.
- status_mie_r, meie_r, msie_r, mtie_r  in  1 each  CSR enables.
- wfi_flag_r  in  1  core is sleeping in WFI.
- irq_take  in  1  the trap for the currently presented irq_cause is taken this cycle.
- ext_complete  in  1  handler completion strobe.
- ext_complete_id  in  ID_W  id being completed.
- irq_req  out  1  interrupt must be processed.
- irq_req_active  out  1  WFI-aware request.
- wfi_irq_req  out  1  WFI wake.
- irq_cause  out  XLEN  mcause value.
- ext_claim_id  out  ID_W  id of the claimed external source.
- ext_busy  out  1  an external claim is outstanding.

## Operation
- **Sampling:** src_q <= src_irq each cycle.
- **Pending, level sources:** pend[i] <= src_q[i].
- **Pending, edge sources:** pend[i] sets on src_q[i] & ~src_q_d[i]. It clears when source i is claimed. If set and clear occur in the same cycle, set wins.
- **Eligibility:** elig[i] = pend[i] & src_en[i] & (prio[i] > prio_thresh).
- **Arbitration:** the winner is the highest priority; ties go to the lowest index. The result is registered into best_id / best_vld.
- **External request:** ext_irq = best_vld & ~ext_busy.
- **Raw request:** raw = (ext_irq & meie_r) | (sft_irq & msie_r) | (tmr_irq & mtie_r).
- **MIE stretch:** mie_d <= status_mie_r. irq_req = ~dbg_mode & (status_mie_r | mie_d) & raw. The one-cycle stretch covers pipe flush.
- **WFI wake:** wfi_irq_req = ~dbg_mode & raw, independent of MIE. irq_req_active = wfi_flag_r ? wfi_irq_req : irq_req.
- **Cause selection:** irq_cause[XLEN-1] = 1. Fixed priority: MEI 11 > MSI 3 > MTI 7. The value is 0 when nothing is enabled and pending.
- **Claim:** occurs on irq_take with cause 11. Effects: ext_claim_id <= best_id, ext_busy <= 1, and an edge pend[best_id] is cleared.
- **Complete:** ext_complete with ext_complete_id == ext_claim_id and ext_busy set clears ext_busy. A mismatched id, or a completion while not busy, is ignored.
- **Debug and disabled sources:** dbg_mode and src_en do not stop edge latching. Pending edges survive and fire later.

## Timing
- **Reset values:** src_q, src_q_d, pend, best_id, best_vld, mie_d, ext_busy and ext_claim_id are all 0. Consequently irq_req = 0, irq_req_active = 0, wfi_irq_req = 0, irq_cause = 0x8000_0000, ext_busy = 0 and ext_claim_id = 0.
- **Latency from external source:** src_irq rising to irq_req is 3 cycles (sample, pend, best register).
- **Latency from sft/tmr:** combinational, 0 cycles.
- **Cause timing:** irq_cause is valid in the same cycle as irq_req.
- **Claim timing:** ext_busy is high the cycle after irq_take, and ext_irq drops that same cycle.
- **Take and complete together:** a claim is impossible while busy, so only the completion takes effect.
- **Completion turnaround:** after a completion, a still-pending source re-requests 1 cycle later.
- **Mid-operation reset:** rst_n low at any time forces the reset values immediately. An outstanding claim is lost.

## Structure
- Package irq_pkg holds:
  - CAUSE_MSI = 3, CAUSE_MTI = 7, CAUSE_MEI = 11;
  - ID_W = $clog2(NUM_SRC) as a function;
  - the priority-compare function.
- Sub-module irq_prio_arb: combinational NUM_SRC-input max-priority selector with lowest-index tie-break. Outputs id and valid.
- The top holds the gateways, registers, claim/complete logic and cause mux.

## Test plan
- **Level arbitration:** src 2 (prio 3) and src 5 (prio 5) both high, thresh 1, all enables set → irq_req 3 cycles later, cause 0x8000_000B. On irq_take, ext_claim_id = 5 and ext_busy = 1.
- **Tie and threshold:** src 1 and src 4 both at prio 4 → claim id 1. Then set thresh = 4 → no request.
- **Edge gateway:** 1-cycle pulse on edge src 3 while dbg_mode = 1 → no irq_req, pend stays set. Drop dbg_mode → request, claim clears pend. A second pulse during busy is pending again after completion.
- **Complete handshake:** ext_complete_id = 2 while claim id = 5 → busy stays 1. Id 5 → busy 0 next cycle.
- **WFI and MIE:** status_mie_r = 0, tmr_irq & mtie_r set, wfi_flag_r = 1 → irq_req_active = 1 and irq_req = 0. Setting status_mie_r and then clearing it → irq_req stays high one extra cycle.
- **Cause priority and reset:** sft, tmr and ext all pending → cause 11. After a claim, cause 3. rst_n pulsed mid-claim → ext_busy = 0 and irq_cause = 0x8000_0000.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants and helpers for the machine-mode interrupt controller.
// Cause codes, id-width helper and the priority comparison used by arbiter and threshold.
package irq_pkg;

    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;
    localparam logic [3:0] CAUSE_MEI = 4'd11;

    // Widest priority the compare helper accepts; callers zero-extend into it.
    localparam int PRIO_MAX_W = 8;

    function automatic int id_w(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

    function automatic logic prio_gt(input logic [PRIO_MAX_W-1:0] a,
                                     input logic [PRIO_MAX_W-1:0] b);
        return a > b;
    endfunction

endpackage

// File: rtl/irq_prio_arb.sv
// Combinational max-priority selector over NUM_SRC requests.
// Strict greater-than while scanning upward gives ties to the lowest index.
module irq_prio_arb
    import irq_pkg::*;
#(
    parameter  int NUM_SRC = 8,
    parameter  int PRIO_W  = 3,
    localparam int ID_W    = id_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]        i_req,
    input  logic [NUM_SRC*PRIO_W-1:0] i_prio,
    output logic [ID_W-1:0]           o_id,
    output logic                      o_vld
);

    logic [ID_W-1:0]   w_id;
    logic              w_vld;
    logic [PRIO_W-1:0] w_prio;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        w_id   = '0;
        w_vld  = 1'b0;
        w_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i_req[i] &&
                (!w_vld || prio_gt(PRIO_MAX_W'(i_prio[i*PRIO_W +: PRIO_W]),
                                   PRIO_MAX_W'(w_prio)))) begin
                w_vld  = 1'b1;
                w_id   = ID_W'(i);
                w_prio = i_prio[i*PRIO_W +: PRIO_W];
            end
        end
    end

    assign o_id  = w_id;
    assign o_vld = w_vld;

endmodule

// File: rtl/excp_irq_ctrl.sv
// Machine-mode interrupt controller: source gateways, registered arbitration,
// claim/complete handshake, MIE stretch, WFI wake and mcause selection.
module excp_irq_ctrl
    import irq_pkg::*;
#(
    parameter  int XLEN    = 32,
    parameter  int NUM_SRC = 8,
    parameter  int PRIO_W  = 3,
    localparam int ID_W    = id_w(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      dbg_mode,
    input  logic [NUM_SRC-1:0]        src_irq,
    input  logic [NUM_SRC-1:0]        src_edge,
    input  logic [NUM_SRC-1:0]        src_en,
    input  logic [NUM_SRC*PRIO_W-1:0] src_prio,
    input  logic [PRIO_W-1:0]         prio_thresh,
    input  logic                      sft_irq,
    input  logic                      tmr_irq,
    input  logic                      status_mie_r,
    input  logic                      meie_r,
    input  logic                      msie_r,
    input  logic                      mtie_r,
    input  logic                      wfi_flag_r,
    input  logic                      irq_take,
    input  logic                      ext_complete,
    input  logic [ID_W-1:0]           ext_complete_id,
    output logic                      irq_req,
    output logic                      irq_req_active,
    output logic                      wfi_irq_req,
    output logic [XLEN-1:0]           irq_cause,
    output logic [ID_W-1:0]           ext_claim_id,
    output logic                      ext_busy
);

    logic [NUM_SRC-1:0] r_src_q;
    logic [NUM_SRC-1:0] r_src_q_d;
    logic [NUM_SRC-1:0] r_pend;
    logic [ID_W-1:0]    r_best_id;
    logic               r_best_vld;
    logic               r_mie_d;
    logic               r_ext_busy;
    logic [ID_W-1:0]    r_ext_claim_id;

    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_elig;
    logic [NUM_SRC-1:0] w_pend_nxt;
    logic [ID_W-1:0]    w_arb_id;
    logic               w_arb_vld;
    logic               w_ext_irq;
    logic               w_mei;
    logic               w_msi;
    logic               w_mti;
    logic               w_raw;
    logic               w_claim;
    logic               w_complete;
    logic [3:0]         w_code;

    assign w_rise = r_src_q & ~r_src_q_d;

    // Edge pendings keep latching regardless of enable or debug; a fresh rise beats a claim clear.
    always_comb begin
        w_pend_nxt = '0;
        w_elig     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_edge[i]) begin
                w_pend_nxt[i] = w_rise[i] |
                                (r_pend[i] & ~(w_claim && (r_best_id == ID_W'(i))));
            end else begin
                w_pend_nxt[i] = r_src_q[i];
            end
            w_elig[i] = r_pend[i] & src_en[i] &
                        prio_gt(PRIO_MAX_W'(src_prio[i*PRIO_W +: PRIO_W]),
                                PRIO_MAX_W'(prio_thresh));
        end
    end

    irq_prio_arb #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W)
    ) u_arb (
        .i_req  (w_elig),
        .i_prio (src_prio),
        .o_id   (w_arb_id),
        .o_vld  (w_arb_vld)
    );

    assign w_ext_irq = r_best_vld & ~r_ext_busy;
    assign w_mei     = w_ext_irq & meie_r;
    assign w_msi     = sft_irq & msie_r;
    assign w_mti     = tmr_irq & mtie_r;
    assign w_raw     = w_mei | w_msi | w_mti;

    assign w_code = w_mei ? CAUSE_MEI :
                    w_msi ? CAUSE_MSI :
                    w_mti ? CAUSE_MTI : 4'd0;

    // A claim needs MEI presented, which already implies not busy, so claim and complete never collide.
    assign w_claim    = irq_take & w_mei;
    assign w_complete = ext_complete & r_ext_busy & (ext_complete_id == r_ext_claim_id);

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_q        <= '0;
            r_src_q_d      <= '0;
            r_pend         <= '0;
            r_best_id      <= '0;
            r_best_vld     <= 1'b0;
            r_mie_d        <= 1'b0;
            r_ext_busy     <= 1'b0;
            r_ext_claim_id <= '0;
        end else begin
            r_src_q    <= src_irq;
            r_src_q_d  <= r_src_q;
            r_pend     <= w_pend_nxt;
            r_best_id  <= w_arb_id;
            r_best_vld <= w_arb_vld;
            r_mie_d    <= status_mie_r;
            if (w_complete) begin
                r_ext_busy <= 1'b0;
            end else if (w_claim) begin
                r_ext_busy     <= 1'b1;
                r_ext_claim_id <= r_best_id;
            end
        end
    end

    assign wfi_irq_req    = ~dbg_mode & w_raw;
    assign irq_req        = ~dbg_mode & (status_mie_r | r_mie_d) & w_raw;
    assign irq_req_active = wfi_flag_r ? wfi_irq_req : irq_req;
    assign irq_cause      = {1'b1, {(XLEN-5){1'b0}}, w_code};
    assign ext_claim_id   = r_ext_claim_id;
    assign ext_busy       = r_ext_busy;

endmodule

// File: tb/tb_excp_irq_ctrl.sv
// Directed bench for excp_irq_ctrl; expectations are queued when stimulus is
// driven and popped when the corresponding output is sampled.
module tb_excp_irq_ctrl;

    localparam int XLEN    = 32;
    localparam int NUM_SRC = 8;
    localparam int PRIO_W  = 3;
    localparam int ID_W    = 3;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      dbg_mode;
    logic [NUM_SRC-1:0]        src_irq;
    logic [NUM_SRC-1:0]        src_edge;
    logic [NUM_SRC-1:0]        src_en;
    logic [NUM_SRC*PRIO_W-1:0] src_prio;
    logic [PRIO_W-1:0]         prio_thresh;
    logic                      sft_irq;
    logic                      tmr_irq;
    logic                      status_mie_r;
    logic                      meie_r;
    logic                      msie_r;
    logic                      mtie_r;
    logic                      wfi_flag_r;
    logic                      irq_take;
    logic                      ext_complete;
    logic [ID_W-1:0]           ext_complete_id;
    logic                      irq_req;
    logic                      irq_req_active;
    logic                      wfi_irq_req;
    logic [XLEN-1:0]           irq_cause;
    logic [ID_W-1:0]           ext_claim_id;
    logic                      ext_busy;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    excp_irq_ctrl #(
        .XLEN    (XLEN),
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dbg_mode        (dbg_mode),
        .src_irq         (src_irq),
        .src_edge        (src_edge),
        .src_en          (src_en),
        .src_prio        (src_prio),
        .prio_thresh     (prio_thresh),
        .sft_irq         (sft_irq),
        .tmr_irq         (tmr_irq),
        .status_mie_r    (status_mie_r),
        .meie_r          (meie_r),
        .msie_r          (msie_r),
        .mtie_r          (mtie_r),
        .wfi_flag_r      (wfi_flag_r),
        .irq_take        (irq_take),
        .ext_complete    (ext_complete),
        .ext_complete_id (ext_complete_id),
        .irq_req         (irq_req),
        .irq_req_active  (irq_req_active),
        .wfi_irq_req     (wfi_irq_req),
        .irq_cause       (irq_cause),
        .ext_claim_id    (ext_claim_id),
        .ext_busy        (ext_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "simulation time limit expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_empty observed=%0h required=queued_expectation", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic set_prio(input int idx, input logic [PRIO_W-1:0] p);
        src_prio[idx*PRIO_W +: PRIO_W] = p;
    endtask

    initial begin
        rst_n           = 1'b0;
        dbg_mode        = 1'b0;
        src_irq         = '0;
        src_edge        = '0;
        src_en          = '1;
        src_prio        = '0;
        prio_thresh     = 3'd1;
        sft_irq         = 1'b0;
        tmr_irq         = 1'b0;
        status_mie_r    = 1'b1;
        meie_r          = 1'b1;
        msie_r          = 1'b1;
        mtie_r          = 1'b1;
        wfi_flag_r      = 1'b0;
        irq_take        = 1'b0;
        ext_complete    = 1'b0;
        ext_complete_id = '0;

        // Reset state
        tick();
        tick();
        sb_push("rst_req", 0);          check(32'(irq_req));
        sb_push("rst_req_active", 0);   check(32'(irq_req_active));
        sb_push("rst_wfi", 0);          check(32'(wfi_irq_req));
        sb_push("rst_cause", 32'h8000_0000); check(irq_cause);
        sb_push("rst_busy", 0);         check(32'(ext_busy));
        sb_push("rst_claim_id", 0);     check(32'(ext_claim_id));
        rst_n = 1'b1;
        tick();

        // Level arbitration: src2 prio3, src5 prio5
        set_prio(2, 3'd3);
        set_prio(5, 3'd5);
        src_irq = 8'b0010_0100;
        sb_push("lvl_req_cyc2", 0);
        sb_push("lvl_req_cyc3", 1);
        sb_push("lvl_cause", 32'h8000_000B);
        tick();
        tick();
        check(32'(irq_req));
        tick();
        check(32'(irq_req));
        check(irq_cause);
        irq_take = 1'b1;
        sb_push("lvl_claim_id", 5);
        sb_push("lvl_busy", 1);
        sb_push("lvl_req_busy", 0);
        tick();
        irq_take = 1'b0;
        check(32'(ext_claim_id));
        check(32'(ext_busy));
        check(32'(irq_req));

        // Completion handshake: wrong id ignored, right id clears
        ext_complete    = 1'b1;
        ext_complete_id = 3'd2;
        sb_push("cmp_wrong_busy", 1);
        tick();
        check(32'(ext_busy));
        ext_complete_id = 3'd5;
        sb_push("cmp_right_busy", 0);
        sb_push("cmp_rereq", 1);
        sb_push("cmp_rereq_cause", 32'h8000_000B);
        tick();
        ext_complete = 1'b0;
        check(32'(ext_busy));
        check(32'(irq_req));
        check(irq_cause);
        src_irq = '0;
        sb_push("lvl_drop_req", 0);
        tick();
        tick();
        tick();
        check(32'(irq_req));

        // Tie break and threshold: src1 and src4 both prio4
        src_prio = '0;
        set_prio(1, 3'd4);
        set_prio(4, 3'd4);
        src_irq = 8'b0001_0010;
        sb_push("tie_req", 1);
        tick();
        tick();
        tick();
        check(32'(irq_req));
        irq_take = 1'b1;
        sb_push("tie_claim_id", 1);
        tick();
        irq_take = 1'b0;
        check(32'(ext_claim_id));
        ext_complete    = 1'b1;
        ext_complete_id = 3'd1;
        sb_push("tie_cmp_busy", 0);
        tick();
        ext_complete = 1'b0;
        check(32'(ext_busy));
        prio_thresh = 3'd4;
        sb_push("thresh_req", 0);
        tick();
        check(32'(irq_req));
        src_irq = '0;
        tick();
        tick();
        tick();
        tick();
        prio_thresh = 3'd1;
        src_prio    = '0;
        tick();

        // Edge gateway under debug mode
        src_edge = 8'b0000_1000;
        set_prio(3, 3'd6);
        dbg_mode = 1'b1;
        src_irq  = 8'b0000_1000;
        tick();
        src_irq = '0;
        sb_push("edge_dbg_req", 0);
        sb_push("edge_dbg_wfi", 0);
        tick();
        tick();
        tick();
        check(32'(irq_req));
        check(32'(wfi_irq_req));
        dbg_mode = 1'b0;
        sb_push("edge_fire_req", 1);
        sb_push("edge_fire_cause", 32'h8000_000B);
        #1;
        check(32'(irq_req));
        check(irq_cause);
        irq_take = 1'b1;
        sb_push("edge_claim_id", 3);
        sb_push("edge_claim_busy", 1);
        tick();
        irq_take = 1'b0;
        check(32'(ext_claim_id));
        check(32'(ext_busy));
        src_irq = 8'b0000_1000;
        tick();
        src_irq = '0;
        tick();
        tick();
        ext_complete    = 1'b1;
        ext_complete_id = 3'd3;
        sb_push("edge_repend_busy", 0);
        sb_push("edge_repend_req", 1);
        tick();
        ext_complete = 1'b0;
        check(32'(ext_busy));
        check(32'(irq_req));
        irq_take = 1'b1;
        tick();
        irq_take        = 1'b0;
        ext_complete    = 1'b1;
        ext_complete_id = 3'd3;
        tick();
        ext_complete = 1'b0;
        sb_push("edge_cleared_req", 0);
        tick();
        tick();
        check(32'(irq_req));
        src_edge = '0;
        src_prio = '0;

        // WFI wake with MIE off, then MIE stretch
        status_mie_r = 1'b0;
        tmr_irq      = 1'b1;
        wfi_flag_r   = 1'b1;
        sb_push("wfi_req", 0);
        sb_push("wfi_req_active", 1);
        sb_push("wfi_wake", 1);
        sb_push("wfi_cause", 32'h8000_0007);
        tick();
        check(32'(irq_req));
        check(32'(irq_req_active));
        check(32'(wfi_irq_req));
        check(irq_cause);
        wfi_flag_r   = 1'b0;
        status_mie_r = 1'b1;
        sb_push("mie_on_req", 1);
        tick();
        check(32'(irq_req));
        status_mie_r = 1'b0;
        sb_push("mie_stretch_req", 1);
        sb_push("mie_stretch_active", 1);
        sb_push("mie_off_req", 0);
        #1;
        check(32'(irq_req));
        check(32'(irq_req_active));
        tick();
        check(32'(irq_req));
        status_mie_r = 1'b1;
        tmr_irq      = 1'b0;
        tick();

        // Cause priority then reset mid-claim
        set_prio(5, 3'd5);
        src_irq = 8'b0010_0000;
        sft_irq = 1'b1;
        tmr_irq = 1'b1;
        sb_push("prio_cause_mei", 32'h8000_000B);
        tick();
        tick();
        tick();
        check(irq_cause);
        irq_take = 1'b1;
        sb_push("prio_cause_msi", 32'h8000_0003);
        tick();
        irq_take = 1'b0;
        check(irq_cause);
        sft_irq = 1'b0;
        tmr_irq = 1'b0;
        rst_n   = 1'b0;
        sb_push("rst_mid_busy", 0);
        sb_push("rst_mid_cause", 32'h8000_0000);
        sb_push("rst_mid_claim_id", 0);
        sb_push("rst_mid_req", 0);
        #1;
        check(32'(ext_busy));
        check(irq_cause);
        check(32'(ext_claim_id));
        check(32'(irq_req));
        src_irq = '0;
        tick();
        rst_n = 1'b1;
        tick();

        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sb_leftover observed=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
